// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises fetch (read-only) and data (read/write) requests onto one
// single-port synchronous RAM. Define RAM_ARB_RR_EN for round-robin tie-breaking.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RSP} state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  state_t                state;
  state_t                state_next;
  logic                  gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  any_req;
  logic                  pick_data;
  logic                  pick_write;
  logic                  drive_bus;

`ifdef RAM_ARB_RR_EN
  logic                  last_gnt_q;
`endif

  // Winner selection; a lone request always wins, ties follow the build option
  always_comb begin
    any_req = if_req | d_req;
`ifdef RAM_ARB_RR_EN
    pick_data = d_req & (~if_req | (last_gnt_q == GNT_FETCH));
`else
    pick_data = d_req;
`endif
    pick_write = pick_data & d_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = pick_write ? WR : RD0;
        end
      end
      RD0:     state_next = RD1;
      RD1:     state_next = RSP;
      WR:      state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The bus is only ever driven in WR, where output enable is guaranteed low
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    drive_bus = 1'b0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    case (state)
      RD0, RD1: begin
        mem_cs = 1'b1;
        mem_oe = 1'b1;
      end
      WR: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        drive_bus = 1'b1;
      end
      RSP: begin
        if_ready = (gnt_q == GNT_FETCH);
        d_ready  = (gnt_q == GNT_DATA);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= GNT_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_q   <= pick_data;
      addr_q  <= pick_data ? d_addr : if_addr;
      wdata_q <= d_wdata;
    end
  end

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GNT_FETCH;
    end else if (state == IDLE && any_req) begin
      last_gnt_q <= pick_data;
    end
  end
`endif

  // The RAM drives its word during RD1; capture it for the port that owns the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (state == RD1) begin
      if (gnt_q == GNT_DATA) begin
        d_rdata_q <= mem_data;
      end else begin
        if_rdata_q <= mem_data;
      end
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = drive_bus ? wdata_q : {DATA_WIDTH{1'bz}};
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  bus_excl_a: assert property (@(posedge clk) disable iff (!rst_n) !(mem_we && mem_oe));

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives ram_arbiter against a small RAM device model and checks every
// cycle against a transaction-level reference model kept in the bench.
module tb_ram_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

`ifdef RAM_ARB_RR_EN
  localparam logic [3:0] EXP_TIE = 4'b1010;
`else
  localparam logic [3:0] EXP_TIE = 4'b1111;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // RAM device: latches a word when selected for read, drives it the following cycle
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  logic [DW-1:0] ram_dout = '0;
  logic          ram_drive = 1'b0;

  always @(posedge clk) begin
    if (mem_cs && mem_we) ram_mem[mem_addr] = mem_data;
    if (mem_cs && mem_oe && !mem_we) begin
      ram_dout  <= ram_mem.exists(mem_addr) ? ram_mem[mem_addr] : '0;
      ram_drive <= 1'b1;
    end else begin
      ram_drive <= 1'b0;
    end
  end

  assign mem_data = (ram_drive && mem_oe) ? ram_dout : {DW{1'bz}};

  // Reference model: one transaction at a time, tracked by cycle offset from the grant
  logic [DW-1:0] shadow [logic [AW-1:0]];
  bit            m_busy = 1'b0;
  int            m_k = 0;
  bit            m_wr = 1'b0;
  bit            m_port = 1'b0;
  bit            m_last = 1'b0;
  bit            take_data;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k = 0;
      m_last = 1'b0;
      m_if_rdata = '0;
      m_d_rdata = '0;
    end else if (m_busy) begin
      m_k = m_k + 1;
      if (m_k > (m_wr ? 2 : 3)) begin
        m_busy = 1'b0;
        m_k = 0;
      end else if (!m_wr && m_k == 3) begin
        if (m_port) m_d_rdata = peek(m_addr);
        else m_if_rdata = peek(m_addr);
      end
    end else if (if_req || d_req) begin
`ifdef RAM_ARB_RR_EN
      take_data = d_req && (!if_req || !m_last);
`else
      take_data = d_req;
`endif
      m_busy = 1'b1;
      m_k = 1;
      m_port = take_data;
      m_last = take_data;
      m_wr = take_data && d_we;
      m_addr = take_data ? d_addr : if_addr;
      m_wdata = d_wdata;
      if (m_wr) shadow[m_addr] = m_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int len;
    len = m_wr ? 2 : 3;
    checkOutput("mem_cs", mem_cs, m_busy && m_k < len);
    checkOutput("mem_oe", mem_oe, m_busy && !m_wr && m_k < 3);
    checkOutput("mem_we", mem_we, m_busy && m_wr && m_k == 1);
    checkOutput("if_ready", if_ready, m_busy && m_k == len && !m_port);
    checkOutput("d_ready", d_ready, m_busy && m_k == len && m_port);
    checkOutput("if_rdata", if_rdata, m_if_rdata);
    checkOutput("d_rdata", d_rdata, m_d_rdata);
    checkOutput("we_oe_excl", mem_we & mem_oe, 0);
    if (m_busy && m_k < len) checkOutput("mem_addr", mem_addr, m_addr);
    if (mem_we) checkOutput("mem_data_wr", mem_data, m_wdata);
  end

  // One access on a port; returns cycles from sample edge to ready and mem_we cycles seen
  task automatic applyStimulus(input bit port, input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, output int lat, output int we_cycles);
    bit seen = 1'b0;
    lat = 0;
    we_cycles = 0;
    if (port) begin
      d_we = we;
      d_addr = a;
      d_wdata = wd;
      d_req = 1'b1;
    end else begin
      if_addr = a;
      if_req = 1'b1;
    end
    while (!seen && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_we) we_cycles++;
      seen = port ? d_ready : if_ready;
    end
    checkOutput(port ? "d_ready_seen" : "if_ready_seen", seen, 1);
    @(posedge clk);
    #1;
    if (port) d_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, wc, lat2, wc2, n;
    int seq[$];
    logic [3:0] code;
    logic [AW-1:0] pool [4];
    pool[0] = 30'h10;
    pool[1] = 30'h3FFF_FFFF;
    pool[2] = 30'h20;
    pool[3] = 30'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_cs", mem_cs, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_oe", mem_oe, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_if_ready", if_ready, 0);
    checkOutput("rst_d_ready", d_ready, 0);
    checkOutput("rst_if_rdata", if_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1, 1, 30'h10, 32'hDEADBEEF, lat, wc);
    checkOutput("wr_latency", lat, 2);
    checkOutput("wr_we_cycles", wc, 1);
    applyStimulus(1, 0, 30'h10, 32'h0, lat, wc);
    checkOutput("rd_latency", lat, 3);
    checkOutput("rd_data", d_rdata, 32'hDEADBEEF);

    applyStimulus(1, 1, 30'h3FFF_FFFF, 32'h12345678, lat, wc);
    checkOutput("wr_keeps_d_rdata", d_rdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 30'h3FFF_FFFF, 32'h0, lat, wc);
    checkOutput("fetch_latency", lat, 3);
    checkOutput("fetch_data", if_rdata, 32'h12345678);
    checkOutput("fetch_keeps_d_rdata", d_rdata, 32'hDEADBEEF);

    // Abort a read in RD1 with an asynchronous reset
    @(posedge clk);
    #1;
    d_we = 1'b0;
    d_addr = 30'h10;
    d_req = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("rd1_oe", mem_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_cs", mem_cs, 0);
    checkOutput("abort_oe", mem_oe, 0);
    checkOutput("abort_d_ready", d_ready, 0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort_d_rdata", d_rdata, 0);
    applyStimulus(1, 0, 30'h10, 32'h0, lat, wc);
    checkOutput("post_abort_latency", lat, 3);
    checkOutput("post_abort_data", d_rdata, 32'hDEADBEEF);

    // Fresh reset so the first tie sees last-grant = fetch
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    if_addr = 30'h3FFF_FFFF;
    if_req = 1'b1;
    d_we = 1'b0;
    d_addr = 30'h10;
    d_req = 1'b1;
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      @(posedge clk);
      #1;
      if (d_ready) seq.push_back(1);
      if (if_ready) seq.push_back(0);
    end
    checkOutput("tie_count", seq.size(), 4);
    code = '0;
    for (int i = 0; i < seq.size() && i < 4; i++) code[3-i] = seq[i][0];
    checkOutput("tie_order", code, EXP_TIE);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    n = 0;
    while (n < 20 && !if_ready) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("fetch_after_drop", n, 3);
    checkOutput("fetch_after_drop_data", if_rdata, 32'h12345678);
    @(posedge clk);
    #1;
    if_req = 1'b0;

    // Mixed traffic, both ports at once in some iterations
    for (int it = 0; it < 30; it++) begin
      int sel;
      bit rw;
      logic [DW-1:0] wd;
      logic [AW-1:0] a0, a1;
      sel = $urandom_range(0, 2);
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      a0 = pool[$urandom_range(0, 3)];
      a1 = pool[$urandom_range(0, 3)];
      case (sel)
        0: applyStimulus(1, rw, a0, wd, lat, wc);
        1: applyStimulus(0, 0, a1, '0, lat, wc);
        default: begin
          fork
            applyStimulus(1, rw, a0, wd, lat, wc);
            applyStimulus(0, 0, a1, '0, lat2, wc2);
          join
        end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
